// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one CORDIC between two requesters.
// Round-robin channel ownership (IDLE/GRANT/DRAIN); the owner's
// vectoring/rotation operands are muxed onto the cordic_* outputs,
// outstanding operations are counted per type, and result valids are
// routed back to the owner. The channel is only released once every
// forwarded operation has returned.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req / gnt           per-requester channel request / one-hot grant
//   r_vec_* / r_rot_*   per-requester operands and strobes (2 slices)
//   cordic_*            muxed operands to the shared CORDIC
//   cordic_nrst         registered active-low CORDIC reset
//   cordic_*_opvld      result valids from the CORDIC
//   r_*_opvld           result valids routed to the owner
//   stall               owner enable dropped (counter full)
//   err                 sticky protocol error
module cordic_arbiter #(
    parameter int DATA_WIDTH    = 16,
    parameter int ANGLE_WIDTH   = 16,
    parameter int CORDIC_STAGES = 16,
    parameter int CNT_W         = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req,
    output logic [1:0]                 gnt,
    input  logic [1:0]                 r_vec_en,
    input  logic [1:0]                 r_vec_angle_calc_en,
    input  logic [2*DATA_WIDTH-1:0]    r_vec_xin,
    input  logic [2*DATA_WIDTH-1:0]    r_vec_yin,
    input  logic [1:0]                 r_rot_en,
    input  logic [1:0]                 r_rot_angle_microRot_n,
    input  logic [1:0]                 r_rot_microRot_ext_vld,
    input  logic [2*DATA_WIDTH-1:0]    r_rot_xin,
    input  logic [2*DATA_WIDTH-1:0]    r_rot_yin,
    input  logic [2*ANGLE_WIDTH-1:0]   r_rot_angle_in,
    input  logic [3:0]                 r_rot_quad_in,
    input  logic [2*CORDIC_STAGES-1:0] r_rot_microRot_ext_in,
    output logic                       cordic_vec_en,
    output logic                       cordic_vec_angle_calc_en,
    output logic [DATA_WIDTH-1:0]      cordic_vec_xin,
    output logic [DATA_WIDTH-1:0]      cordic_vec_yin,
    output logic                       cordic_rot_en,
    output logic                       cordic_rot_angle_microRot_n,
    output logic                       cordic_rot_microRot_ext_vld,
    output logic [DATA_WIDTH-1:0]      cordic_rot_xin,
    output logic [DATA_WIDTH-1:0]      cordic_rot_yin,
    output logic [ANGLE_WIDTH-1:0]     cordic_rot_angle_in,
    output logic [1:0]                 cordic_rot_quad_in,
    output logic [CORDIC_STAGES-1:0]   cordic_rot_microRot_ext_in,
    output logic                       cordic_nrst,
    input  logic                       cordic_vec_opvld,
    input  logic                       cordic_rot_opvld,
    output logic [1:0]                 r_vec_opvld,
    output logic [1:0]                 r_rot_opvld,
    output logic                       stall,
    output logic                       err
);

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_e;

    localparam logic [CNT_W-1:0] OUT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] rot_cnt_q, rot_cnt_d;
    logic             err_q, err_d;
    logic             nrst_dly_q, cordic_nrst_q;

    logic active, granting, vld_ok, pick;
    logic own_vec_en, own_rot_en, vec_full, rot_full;
    logic vec_fwd, rot_fwd, vec_dec, rot_dec, vec_bad, rot_bad;

    // Channel is live whenever an owner holds gnt (GRANT or DRAIN).
    assign active     = (gnt_q != 2'b00) && !rst;
    assign granting   = active && (state_q == GRANT);
    // While the CORDIC is held in reset its valids are stale: drop them.
    assign vld_ok     = cordic_nrst_q && !rst;
    assign own_vec_en = r_vec_en[owner_q];
    assign own_rot_en = r_rot_en[owner_q];
    assign vec_full   = (vec_cnt_q == OUT_MAX);
    assign rot_full   = (rot_cnt_q == OUT_MAX);
    assign vec_fwd    = granting && own_vec_en && !vec_full;
    assign rot_fwd    = granting && own_rot_en && !rot_full;
    assign stall      = granting && ((own_vec_en && vec_full) ||
                                     (own_rot_en && rot_full));
    assign vec_dec    = vld_ok && cordic_vec_opvld && (vec_cnt_q != '0);
    assign rot_dec    = vld_ok && cordic_rot_opvld && (rot_cnt_q != '0);
    assign vec_bad    = vld_ok && cordic_vec_opvld &&
                        ((vec_cnt_q == '0) || (state_q == IDLE));
    assign rot_bad    = vld_ok && cordic_rot_opvld &&
                        ((rot_cnt_q == '0) || (state_q == IDLE));
    assign err_d      = err_q || vec_bad || rot_bad;

    // Both requesting: favour the one that did not own the channel last.
    assign pick = (req == 2'b11) ? ~last_q : req[1];

    assign r_vec_opvld = (active && vld_ok && cordic_vec_opvld) ? gnt_q : 2'b00;
    assign r_rot_opvld = (active && vld_ok && cordic_rot_opvld) ? gnt_q : 2'b00;

    assign gnt         = gnt_q;
    assign err         = err_q;
    assign cordic_nrst = cordic_nrst_q;

    always_comb begin
        vec_cnt_d = vec_cnt_q;
        rot_cnt_d = rot_cnt_q;
        if (vec_fwd && !vec_dec) vec_cnt_d = vec_cnt_q + ONE;
        if (!vec_fwd && vec_dec) vec_cnt_d = vec_cnt_q - ONE;
        if (rot_fwd && !rot_dec) rot_cnt_d = rot_cnt_q + ONE;
        if (!rot_fwd && rot_dec) rot_cnt_d = rot_cnt_q - ONE;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    owner_d = pick;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[owner_q]) state_d = DRAIN;
            end
            DRAIN: begin
                if ((vec_cnt_q == '0) && (rot_cnt_q == '0)) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    gnt_d   = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cordic_vec_en               = vec_fwd;
        cordic_rot_en               = rot_fwd;
        cordic_vec_angle_calc_en    = 1'b0;
        cordic_vec_xin              = '0;
        cordic_vec_yin              = '0;
        cordic_rot_angle_microRot_n = 1'b0;
        cordic_rot_microRot_ext_vld = 1'b0;
        cordic_rot_xin              = '0;
        cordic_rot_yin              = '0;
        cordic_rot_angle_in         = '0;
        cordic_rot_quad_in          = '0;
        cordic_rot_microRot_ext_in  = '0;
        if (active) begin
            cordic_vec_angle_calc_en    = r_vec_angle_calc_en[owner_q];
            cordic_rot_angle_microRot_n = r_rot_angle_microRot_n[owner_q];
            cordic_rot_microRot_ext_vld = r_rot_microRot_ext_vld[owner_q];
            cordic_vec_xin = owner_q ? r_vec_xin[2*DATA_WIDTH-1:DATA_WIDTH]
                                     : r_vec_xin[DATA_WIDTH-1:0];
            cordic_vec_yin = owner_q ? r_vec_yin[2*DATA_WIDTH-1:DATA_WIDTH]
                                     : r_vec_yin[DATA_WIDTH-1:0];
            cordic_rot_xin = owner_q ? r_rot_xin[2*DATA_WIDTH-1:DATA_WIDTH]
                                     : r_rot_xin[DATA_WIDTH-1:0];
            cordic_rot_yin = owner_q ? r_rot_yin[2*DATA_WIDTH-1:DATA_WIDTH]
                                     : r_rot_yin[DATA_WIDTH-1:0];
            cordic_rot_angle_in = owner_q
                ? r_rot_angle_in[2*ANGLE_WIDTH-1:ANGLE_WIDTH]
                : r_rot_angle_in[ANGLE_WIDTH-1:0];
            cordic_rot_quad_in = owner_q ? r_rot_quad_in[3:2]
                                         : r_rot_quad_in[1:0];
            cordic_rot_microRot_ext_in = owner_q
                ? r_rot_microRot_ext_in[2*CORDIC_STAGES-1:CORDIC_STAGES]
                : r_rot_microRot_ext_in[CORDIC_STAGES-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= 2'b00;
            owner_q       <= 1'b0;
            last_q        <= 1'b1;
            vec_cnt_q     <= '0;
            rot_cnt_q     <= '0;
            err_q         <= 1'b0;
            nrst_dly_q    <= 1'b0;
            cordic_nrst_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            vec_cnt_q     <= vec_cnt_d;
            rot_cnt_q     <= rot_cnt_d;
            err_q         <= err_d;
            // Two-stage release keeps the CORDIC in reset one extra cycle.
            nrst_dly_q    <= 1'b1;
            cordic_nrst_q <= nrst_dly_q;
        end
    end

endmodule
